// File: rtl/seg_pkg.sv
// Shared encodings for the BCD scan controller: FSM states, digit limit
// and the active-high 7-segment patterns (bit6..0 = g..a).
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;

  // Non-decimal codes cannot occur; they fall back to the blank-free "0" glyph.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit (0-9) of the cascaded counter. q_nxt exposes the value
// the digit takes on the coming edge so the display path can stay aligned.
module bcd_digit
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_in,
  input  logic       clr,
  output logic [3:0] q,
  output logic [3:0] q_nxt,
  output logic       carry_out
);

  assign carry_out = inc_in & (q == BCD_MAX);

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (inc_in) begin
      q_nxt = (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Run/hold/clear controller for cascaded BCD digits with a single shared,
// time-multiplexed 7-segment decoder.
//   state   | meaning
//   ST_IDLE | counts zero, prescaler zero, waiting for start
//   ST_RUN  | prescaler advancing, digits count on each tick
//   ST_HOLD | counts and prescaler frozen, start resumes the partial period
module bcd_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  running,
  output logic                  overflow,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic [6:0]            Segmentos
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [N_DIGITS-1:0] inc;
  logic [N_DIGITS-1:0] carry;
  logic [4*N_DIGITS-1:0] bcd_nxt;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic [N_DIGITS-1:0] digit_en_d;
  logic [3:0]          sel_digit;
  logic [6:0]          seg_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clear dominates; stop only matters in RUN, start only outside RUN.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (stop)  state_d = ST_HOLD;
        ST_HOLD: if (start) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign running = (state_q == ST_RUN);
  assign tick    = running && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else begin
      case (state_q)
        ST_RUN:  presc_d = tick ? '0 : presc_q + PW'(1);
        ST_IDLE: presc_d = '0;
        default: presc_d = presc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Carry ripples combinationally so a full 9..9 rollover lands in one edge.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc[k] = tick;
    end else begin : g_upper
      assign inc[k] = carry[k-1];
    end

    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .inc_in    (inc[k]),
      .clr       (clear),
      .q         (bcd[4*k +: 4]),
      .q_nxt     (bcd_nxt[4*k +: 4]),
      .carry_out (carry[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= carry[N_DIGITS-1] & ~clear;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  // Select and pattern are both taken from next-state values, so the
  // registered digit_en and Segmentos always describe the same digit.
  always_comb begin
    digit_en_d = '0;
    sel_digit  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (scan_idx_d == IW'(k)) begin
        digit_en_d[k] = (scan_cnt_d != '0);
        sel_digit     = bcd_nxt[4*k +: 4];
      end
    end
    seg_d = seg7_decode(sel_digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      digit_en   <= '0;
      Segmentos  <= SEG_0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      digit_en   <= digit_en_d;
      Segmentos  <= seg_d;
    end
  end

endmodule
